// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS-I core: opcodes, functs, FSM states,
// ALU control codes, error codes and the single shared ALU.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
   localparam logic [1:0] ERR_MISALIGN = 2'b10;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEM_ADDR = 4'd2,
      MEM_RD   = 4'd3,
      MEM_WB   = 4'd4,
      MEM_WR   = 4'd5,
      EXEC_R   = 4'd6,
      EXEC_I   = 4'd7,
      ALU_WB   = 4'd8,
      BRANCH   = 4'd9,
      JUMP     = 4'd10,
      HALT     = 4'd15
   } state_t;

   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_SUB = 4'b0110,
      ALU_SLT = 4'b0111
   } alu_ctrl_t;

   function automatic logic funct_ok(input logic [5:0] f);
      return f inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
   endfunction

   function automatic alu_ctrl_t funct_to_alu(input logic [5:0] f);
      case (f)
         FN_SUB:  return ALU_SUB;
         FN_AND:  return ALU_AND;
         FN_OR:   return ALU_OR;
         FN_SLT:  return ALU_SLT;
         default: return ALU_ADD;
      endcase
   endfunction

   function automatic logic [31:0] alu(input alu_ctrl_t c, input logic [31:0] a, input logic [31:0] b);
      case (c)
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_SUB: return a - b;
         ALU_SLT: return {31'b0, ($signed(a) < $signed(b))};
         default: return a + b;
      endcase
   endfunction

endpackage

// File: rtl/mips_mc_regfile.sv
// 32x32 register file: two combinational read ports plus a debug read port,
// one synchronous write port, asynchronous clear. Register 0 is hard zero.
module mips_mc_regfile (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   input  logic [4:0]  dbg_sel,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd,
   output logic [31:0] rd1,
   output logic [31:0] rd2,
   output logic [31:0] dbg_rd
);

   logic [31:0] regs [0:31];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (we && wa != 5'd0) begin
         regs[wa] <= wd;
      end
   end

   assign rd1    = (ra1 == 5'd0)     ? '0 : regs[ra1];
   assign rd2    = (ra2 == 5'd0)     ? '0 : regs[ra2];
   assign dbg_rd = (dbg_sel == 5'd0) ? '0 : regs[dbg_sel];

endmodule

// File: rtl/mips_multi_cycle.sv
// Multi-cycle MIPS-I subset core: one shared ALU, one unified req/ready memory
// port, sticky halt on illegal instruction or misaligned data address.
module mips_multi_cycle
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter bit          DBG_EN          = 1'b1,
   parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   input  logic [4:0]  dbg_sel,
   output logic [31:0] dbg_rdata,
   output logic [31:0] pc,
   output logic [31:0] instr,
   output logic [3:0]  state,
   output logic        retired,
   output logic        halted,
   output logic [1:0]  err_code
);

   state_t      st;
   logic [31:0] pc_r, ir, a, b, alu_out, mdr;
   logic [1:0]  err;

   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd;
   logic [31:0] simm;
   logic        illegal;

   assign op    = ir[31:26];
   assign rs    = ir[25:21];
   assign rt    = ir[20:16];
   assign rd    = ir[15:11];
   assign funct = ir[5:0];
   assign simm  = {{16{ir[15]}}, ir[15:0]};

   assign illegal = (op == OP_RTYPE) ? !funct_ok(funct)
                                     : !(op inside {OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW});

   // Single ALU, operands steered by state: pc+4, branch target, effective address, R-op.
   alu_ctrl_t   alu_c;
   logic [31:0] alu_a, alu_b, alu_y;

   always_comb begin
      alu_a = pc_r;
      alu_b = 32'd4;
      alu_c = ALU_ADD;
      case (st)
         DECODE:           alu_b = simm << 2;
         MEM_ADDR, EXEC_I: begin alu_a = a; alu_b = simm; end
         EXEC_R:           begin alu_a = a; alu_b = b; alu_c = funct_to_alu(funct); end
         default: ;
      endcase
   end

   assign alu_y = alu(alu_c, alu_a, alu_b);

   logic        rf_we;
   logic [4:0]  rf_wa;
   logic [31:0] rf_wd, rf_rd1, rf_rd2, rf_dbg;

   assign rf_we = (st == MEM_WB) || (st == ALU_WB);
   assign rf_wa = (st == MEM_WB || op != OP_RTYPE) ? rt : rd;
   assign rf_wd = (st == MEM_WB) ? mdr : alu_out;

   mips_mc_regfile u_rf (
      .clk     (clk),
      .reset   (reset),
      .ra1     (rs),
      .ra2     (rt),
      .dbg_sel (dbg_sel),
      .we      (rf_we),
      .wa      (rf_wa),
      .wd      (rf_wd),
      .rd1     (rf_rd1),
      .rd2     (rf_rd2),
      .dbg_rd  (rf_dbg)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st      <= FETCH;
         pc_r    <= RESET_PC;
         ir      <= '0;
         a       <= '0;
         b       <= '0;
         alu_out <= '0;
         mdr     <= '0;
         err     <= ERR_NONE;
      end else begin
         case (st)
            FETCH: if (mem_ready) begin
               ir   <= mem_rdata;
               pc_r <= alu_y;
               st   <= DECODE;
            end
            DECODE: begin
               a       <= rf_rd1;
               b       <= rf_rd2;
               alu_out <= alu_y;
               if (illegal) begin
                  st <= HALT_ON_ILLEGAL ? HALT : FETCH;
                  if (HALT_ON_ILLEGAL) err <= ERR_ILLEGAL;
               end else begin
                  case (op)
                     OP_LW, OP_SW: st <= MEM_ADDR;
                     OP_RTYPE:     st <= EXEC_R;
                     OP_ADDI:      st <= EXEC_I;
                     OP_BEQ:       st <= BRANCH;
                     OP_J:         st <= JUMP;
                     default:      st <= HALT;
                  endcase
               end
            end
            MEM_ADDR: begin
               alu_out <= alu_y;
               if (alu_y[1:0] != 2'b00) begin
                  st  <= HALT;
                  err <= ERR_MISALIGN;
               end else begin
                  st <= (op == OP_LW) ? MEM_RD : MEM_WR;
               end
            end
            MEM_RD: if (mem_ready) begin
               mdr <= mem_rdata;
               st  <= MEM_WB;
            end
            MEM_WR: if (mem_ready) st <= FETCH;
            EXEC_R, EXEC_I: begin
               alu_out <= alu_y;
               st      <= ALU_WB;
            end
            BRANCH: begin
               if (a == b) pc_r <= alu_out;
               st <= FETCH;
            end
            JUMP: begin
               pc_r <= {pc_r[31:28], ir[25:0], 2'b00};
               st   <= FETCH;
            end
            MEM_WB, ALU_WB: st <= FETCH;
            default: st <= HALT;
         endcase
      end
   end

   // mem_req gated by reset so an in-flight request drops in the reset cycle itself.
   assign mem_req   = !reset && (st == FETCH || st == MEM_RD || st == MEM_WR);
   assign mem_we    = (st == MEM_WR);
   assign mem_addr  = (st == FETCH) ? pc_r : alu_out;
   assign mem_wdata = b;

   assign retired = (st == MEM_WB) || (st == ALU_WB) || (st == BRANCH) || (st == JUMP) ||
                    (st == MEM_WR && mem_ready) ||
                    (st == DECODE && illegal && !HALT_ON_ILLEGAL);

   assign dbg_rdata = DBG_EN ? rf_dbg : '0;
   assign pc        = pc_r;
   assign instr     = ir;
   assign state     = st;
   assign halted    = (st == HALT);
   assign err_code  = err;

endmodule

// File: tb/tb_mips_multi_cycle.sv
// Bench for mips_multi_cycle: variable-latency memory responder plus an
// instruction-level ISA reference model checked at every retire/halt.
module tb_mips_multi_cycle;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_req, mem_we, mem_ready = 1'b0;
   logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
   logic [4:0]  dbg_sel = '0;
   logic [31:0] dbg_rdata, pc, instr;
   logic [3:0]  state;
   logic        retired, halted;
   logic [1:0]  err_code;

   mips_multi_cycle dut (
      .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .dbg_sel(dbg_sel), .dbg_rdata(dbg_rdata), .pc(pc), .instr(instr), .state(state),
      .retired(retired), .halted(halted), .err_code(err_code)
   );

   initial forever #5 clk = ~clk;

   int n_vec = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   logic [31:0] mem     [0:255];
   logic [31:0] ref_mem [0:255];
   logic [31:0] ref_rf  [0:31];
   logic [31:0] ref_pc;

   // Memory responder
   int fixed_wait = 0, max_wait = 2, wait_tgt = 0, wait_cnt = 0;
   int waits_acc = 0, hs_acc = 0;
   bit active = 0, was_hs = 0, in_wait = 0;
   logic        h_we;
   logic [31:0] h_addr, h_wdata;

   initial forever begin
      @(negedge clk);
      if (reset) begin
         mem_ready = 1'b0; active = 0; was_hs = 0; in_wait = 0;
      end else begin
         if (was_hs) begin active = 0; was_hs = 0; in_wait = 0; end
         if (mem_req) begin
            if (!active) begin
               active = 1; wait_cnt = 0;
               wait_tgt = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, max_wait));
            end
            chk("addr_align", {30'b0, mem_addr[1:0]}, 32'd0);
            if (in_wait) begin
               chk("hold_we", {31'b0, mem_we}, {31'b0, h_we});
               chk("hold_addr", mem_addr, h_addr);
               chk("hold_wdata", mem_wdata, h_wdata);
            end
            if (wait_cnt < wait_tgt) begin
               mem_ready = 1'b0; wait_cnt++; waits_acc++; in_wait = 1;
               h_we = mem_we; h_addr = mem_addr; h_wdata = mem_wdata;
            end else begin
               mem_ready = 1'b1; was_hs = 1; hs_acc++;
               if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
               else        mem_rdata = mem[mem_addr[9:2]];
            end
         end else begin
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
         end
      end
   end

   function automatic logic [31:0] r_t(input logic [5:0] fn, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt);
      return {6'h00, rs, rt, rd, 5'h00, fn};
   endfunction

   function automatic logic [31:0] i_t(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
      logic [4:0] x, y, z;
      x = 5'($urandom_range(0, 15)); y = 5'($urandom_range(0, 15)); z = 5'($urandom_range(0, 15));
      case ($urandom_range(0, 8))
         0, 1, 2, 3, 4: return r_t(fns[$urandom_range(0, 4)], z, x, y);
         5:             return i_t(6'h08, x, y, 16'($urandom));
         6:             return i_t(6'h23, 5'd0, y, 16'(16'h200 + 4 * $urandom_range(0, 15)));
         7:             return i_t(6'h2B, 5'd0, y, 16'(16'h200 + 4 * $urandom_range(0, 15)));
         default:       return i_t(6'h04, x, y, 16'd1);
      endcase
   endfunction

   task automatic put(input logic [31:0] addr, input logic [31:0] w);
      mem[addr[9:2]] = w; ref_mem[addr[9:2]] = w;
   endtask

   // Starts a reset: clean register model, random memory background.
   task automatic reset_begin();
      reset = 1'b1;
      for (int i = 0; i < 32; i++) ref_rf[i] = '0;
      ref_pc = 32'h0;
      for (int i = 0; i < 256; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
      repeat (2) @(posedge clk);
   endtask

   task automatic reset_end();
      fixed_wait = 0; waits_acc = 0; hs_acc = 0;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   // Executes one instruction of the ISA model; base is its zero-wait cycle count
   // (or the cycle halted first shows on a fault).
   task automatic ref_step(output int base, output logic [4:0] dest, output logic [31:0] old,
                           output bit fault, output logic [1:0] ferr);
      logic [31:0] ir, a, b, sim, ea, val;
      ir = ref_mem[ref_pc[9:2]];
      ref_pc = ref_pc + 4;
      a = ref_rf[ir[25:21]]; b = ref_rf[ir[20:16]];
      sim = {{16{ir[15]}}, ir[15:0]};
      dest = 0; val = 0; fault = 0; ferr = 0; base = 3;
      case (ir[31:26])
         6'h00: begin
            base = 4; dest = ir[15:11];
            case (ir[5:0])
               6'h20: val = a + b;
               6'h22: val = a - b;
               6'h24: val = a & b;
               6'h25: val = a | b;
               6'h2A: val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
               default: begin fault = 1; ferr = 2'b01; dest = 0; base = 3; end
            endcase
         end
         6'h08: begin base = 4; dest = ir[20:16]; val = a + sim; end
         6'h23: begin
            ea = a + sim;
            if (ea[1:0] != 0) begin fault = 1; ferr = 2'b10; base = 4; end
            else begin base = 5; dest = ir[20:16]; val = ref_mem[ea[9:2]]; end
         end
         6'h2B: begin
            ea = a + sim; base = 4;
            if (ea[1:0] != 0) begin fault = 1; ferr = 2'b10; end
            else ref_mem[ea[9:2]] = b;
         end
         6'h04: if (a == b) ref_pc = ref_pc + (sim << 2);
         6'h02: ref_pc = {ref_pc[31:28], ir[25:0], 2'b00};
         default: begin fault = 1; ferr = 2'b01; end
      endcase
      old = ref_rf[dest];
      if (!fault && dest != 0) ref_rf[dest] = val;
   endtask

   int total_cyc;

   // mode 1 applies the fixed-latency profile of the directed opening program.
   task automatic run(input int mode, input int nsteps);
      int base, cyc;
      logic [4:0] dest;
      logic [31:0] old;
      bit fault;
      logic [1:0] ferr;
      total_cyc = 0;
      for (int k = 0; k < nsteps; k++) begin
         fixed_wait = (mode == 1 && k < 4) ? 0 : (mode == 1 && k < 6) ? 3 : -1;
         ref_step(base, dest, old, fault, ferr);
         dbg_sel = dest;
         cyc = 0;
         do begin @(negedge clk); #1; cyc++; end
         while (!(fault ? halted : retired) && cyc < 300);
         chk(fault ? "halt_seen" : "retire_seen", {31'b0, fault ? halted : retired}, 32'd1);
         chk("latency", cyc, base + waits_acc);
         if (mode == 1 && k == 5) chk("lw_latency", cyc, 32'd11);
         if (fault) begin
            chk("err_code", {30'b0, err_code}, {30'b0, ferr});
            chk("halt_pc", pc, ref_pc);
            chk("fault_handshakes", hs_acc, 32'd1);
            repeat (4) begin
               @(negedge clk); #1;
               chk("halt_no_req", {31'b0, mem_req}, 32'd0);
               chk("halt_sticky", {31'b0, halted}, 32'd1);
            end
            return;
         end
         total_cyc += cyc;
         if (mode == 1 && k == 3) chk("four_instr_cycles", total_cyc, 32'd16);
         chk("dbg_old", dbg_rdata, old);
         @(posedge clk); #1;
         chk("pc", pc, ref_pc);
         chk("wb_value", dbg_rdata, ref_rf[dest]);
         if (mode == 1 && k == 4) chk("sw_landed", mem[4], 32'd12);
         waits_acc = 0; hs_acc = 0;
      end
   endtask

   initial begin
      int cyc;
      // Reset state
      reset_begin();
      #2;
      chk("rst_pc", pc, 32'h0);
      chk("rst_state", {28'b0, state}, 32'd0);
      chk("rst_ir", instr, 32'h0);
      chk("rst_req", {31'b0, mem_req}, 32'd0);
      chk("rst_halted", {31'b0, halted}, 32'd0);
      chk("rst_err", {30'b0, err_code}, 32'd0);
      chk("rst_retired", {31'b0, retired}, 32'd0);

      // Directed opening program, then a random block ending in an illegal opcode
      put(32'h00, i_t(6'h08, 0, 8, 16'd5));
      put(32'h04, i_t(6'h08, 0, 9, 16'd7));
      put(32'h08, r_t(6'h20, 10, 8, 9));
      put(32'h0C, r_t(6'h22, 11, 9, 8));
      put(32'h10, i_t(6'h2B, 0, 10, 16'h10));
      put(32'h14, i_t(6'h23, 0, 12, 16'h10));
      put(32'h18, r_t(6'h24, 13, 8, 9));
      put(32'h1C, r_t(6'h25, 14, 11, 8));
      put(32'h20, i_t(6'h04, 8, 8, 16'd2));
      put(32'h24, i_t(6'h08, 0, 1, 16'd1));
      put(32'h28, i_t(6'h08, 0, 1, 16'd2));
      put(32'h2C, i_t(6'h04, 8, 9, 16'd2));
      put(32'h30, {6'h02, 26'h40});
      put(32'h100, r_t(6'h2A, 15, 11, 8));
      for (int i = 1; i <= 30; i++) put(32'h100 + 4 * i, rand_instr());
      put(32'h17C, {6'h3F, 26'($urandom)});
      put(32'h180, {6'h3F, 26'($urandom)});
      reset_end();
      run(1, 60);

      // Misaligned load: halts before any data request
      reset_begin();
      put(32'h00, i_t(6'h23, 0, 8, 16'd1));
      reset_end();
      run(0, 1);

      // Reset in the middle of a stalled store
      reset_begin();
      put(32'h00, i_t(6'h08, 0, 8, 16'd9));
      put(32'h04, i_t(6'h2B, 0, 8, 16'h200));
      reset_end();
      run(0, 1);
      fixed_wait = 8;
      cyc = 0;
      while (state !== 4'd5 && cyc < 60) begin @(negedge clk); #1; cyc++; end
      chk("reach_mem_wr", {28'b0, state}, 32'd5);
      repeat (2) @(negedge clk);
      #1;
      chk("wr_pending_req", {31'b0, mem_req}, 32'd1);
      chk("wr_pending_we", {31'b0, mem_we}, 32'd1);
      chk("wr_pending_addr", mem_addr, 32'h200);
      chk("wr_pending_data", mem_wdata, 32'd9);
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("rst_drop_req", {31'b0, mem_req}, 32'd0);
      chk("rst_mid_state", {28'b0, state}, 32'd0);
      chk("rst_mid_pc", pc, 32'h0);
      dbg_sel = 5'd8; #1;
      chk("rst_mid_reg8", dbg_rdata, 32'd0);
      chk("store_dropped", mem[128], ref_mem[128]);
      reset_begin();
      put(32'h00, i_t(6'h08, 0, 0, 16'd9));
      put(32'h04, r_t(6'h21, 3, 1, 2));
      reset_end();
      run(0, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
